// File: rtl/rt_pkg.sv
// Shared types and constants for the pixel scan sequencer.
// Sub-pixel offsets are counted in quarter pixels and are shifted into the fraction field by the user.
package rt_pkg;

    localparam int unsigned DIM_W     = 12;
    localparam int unsigned CAMERA_IW = 16;
    localparam int unsigned CAMERA_QW = 16;

    // Quarter-pixel units: 0.25 and 0.75 of a pixel.
    localparam logic [1:0] SUB_OFF_LO = 2'd1;
    localparam logic [1:0] SUB_OFF_HI = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rt_scan_state_e;

    typedef struct packed {
        logic [DIM_W-1:0] col;
        logic [DIM_W-1:0] row;
        logic [1:0]       sample;
    } rt_pix_tag_t;

    function automatic logic [1:0] sub_off(input logic hi);
        return hi ? SUB_OFF_HI : SUB_OFF_LO;
    endfunction

endpackage

// File: rtl/rt_raster_ctr.sv
// Row-major 2-D wrap counter. Holds the latched frame size and exposes both the current
// position and the position one advance ahead, so the caller can register derived outputs.
module rt_raster_ctr #(
    parameter int unsigned DIM_W = rt_pkg::DIM_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic [DIM_W-1:0] col_o,
    output logic [DIM_W-1:0] row_o,
    output logic [DIM_W-1:0] col_nxt_o,
    output logic [DIM_W-1:0] row_nxt_o,
    output logic             last_o,
    output logic             last_nxt_o
);

    logic [DIM_W-1:0] col_q, row_q;
    logic [DIM_W-1:0] w_m1_q, h_m1_q;
    logic             col_wrap;

    assign col_wrap   = (col_q == w_m1_q);
    assign col_nxt_o  = col_wrap ? '0 : col_q + DIM_W'(1);
    assign row_nxt_o  = col_wrap ? row_q + DIM_W'(1) : row_q;
    assign col_o      = col_q;
    assign row_o      = row_q;
    assign last_o     = col_wrap && (row_q == h_m1_q);
    assign last_nxt_o = (col_nxt_o == w_m1_q) && (row_nxt_o == h_m1_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q  <= '0;
            row_q  <= '0;
            w_m1_q <= '0;
            h_m1_q <= '0;
        end else if (clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (load_i) begin
            // Zero sizes never get here; the caller routes them straight to DONE.
            w_m1_q <= width_i - DIM_W'(1);
            h_m1_q <= height_i - DIM_W'(1);
            col_q  <= '0;
            row_q  <= '0;
        end else if (advance_i) begin
            col_q <= col_nxt_o;
            row_q <= row_nxt_o;
        end
    end

endmodule

// File: rtl/rt_pixel_scan.sv
// Frame pixel coordinate sequencer feeding ray generation with fixed-point (x,y) plus pixel tags.
// Define RT_SCAN_SUPERSAMPLE_EN for four stratified samples per pixel on a 2x2 grid.
module rt_pixel_scan #(
    parameter int unsigned DIM_W = rt_pkg::DIM_W,
    parameter int unsigned IW    = rt_pkg::CAMERA_IW,
    parameter int unsigned QW    = rt_pkg::CAMERA_QW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DIM_W-1:0]   width_i,
    input  logic [DIM_W-1:0]   height_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [IW+QW-1:0]   x_o,
    output logic [IW+QW-1:0]   y_o,
    output logic [DIM_W-1:0]   col_o,
    output logic [DIM_W-1:0]   row_o,
    output logic [1:0]         sample_o,
    output logic               last_o,
    output logic               busy_o,
    output logic               done_o
);
    import rt_pkg::*;

    localparam int unsigned FW = IW + QW;

    rt_scan_state_e   state_q;
    rt_pix_tag_t      nxt_tag;
    logic             xfer, frame_end, start_hit, start_ok, start_last;
    logic             ctr_clear, ctr_load, ctr_advance, pix_adv;
    logic [DIM_W-1:0] ctr_col, ctr_row, ctr_col_nxt, ctr_row_nxt;
    logic             ctr_last, ctr_last_nxt, last_nxt;
    logic [1:0]       sample_q, sample_nxt, sample_last;
    logic [1:0]       dx0, dy0, dx_nxt, dy_nxt;

    function automatic logic [FW-1:0] to_fx(input logic [DIM_W-1:0] v, input logic [1:0] off);
        logic [FW-1:0] base;
        logic [FW-1:0] frac;
        base = {{(IW-DIM_W){1'b0}}, v, {QW{1'b0}}};
        frac = {{(FW-2){1'b0}}, off} << (QW-2);
        return base + frac;
    endfunction

    assign xfer      = valid_o & ready_i;
    assign frame_end = xfer & last_o;
    assign start_hit = (state_q == IDLE) & start_i & ~abort_i;
    assign start_ok  = start_hit & (width_i != '0) & (height_i != '0);

`ifdef RT_SCAN_SUPERSAMPLE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= 2'd0;
        end else if (abort_i || frame_end || start_ok) begin
            sample_q <= 2'd0;
        end else if (xfer) begin
            sample_q <= sample_nxt;
        end
    end

    assign sample_nxt  = sample_q + 2'd1;
    assign sample_last = 2'd3;
    assign pix_adv     = xfer & (sample_q == 2'd3);
    assign dx0         = SUB_OFF_LO;
    assign dy0         = SUB_OFF_LO;
    assign dx_nxt      = sub_off(nxt_tag.sample[0]);
    assign dy_nxt      = sub_off(nxt_tag.sample[1]);
`else
    assign sample_q    = 2'd0;
    assign sample_nxt  = 2'd0;
    assign sample_last = 2'd0;
    assign pix_adv     = xfer;
    assign dx0         = 2'd0;
    assign dy0         = 2'd0;
    assign dx_nxt      = 2'd0;
    assign dy_nxt      = 2'd0;
`endif

    // A single-pixel frame is final on its first sample only without supersampling.
    assign start_last  = (sample_last == 2'd0) & (width_i == DIM_W'(1)) & (height_i == DIM_W'(1));
    assign last_nxt    = (sample_nxt == sample_last) & (pix_adv ? ctr_last_nxt : ctr_last);

    assign ctr_clear   = abort_i | frame_end;
    assign ctr_load    = start_ok;
    assign ctr_advance = (state_q == RUN) & pix_adv & ~last_o;

    always_comb begin
        nxt_tag        = '0;
        nxt_tag.col    = pix_adv ? ctr_col_nxt : ctr_col;
        nxt_tag.row    = pix_adv ? ctr_row_nxt : ctr_row;
        nxt_tag.sample = sample_nxt;
    end

    rt_raster_ctr #(
        .DIM_W (DIM_W)
    ) u_raster_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (ctr_clear),
        .load_i     (ctr_load),
        .advance_i  (ctr_advance),
        .width_i    (width_i),
        .height_i   (height_i),
        .col_o      (ctr_col),
        .row_o      (ctr_row),
        .col_nxt_o  (ctr_col_nxt),
        .row_nxt_o  (ctr_row_nxt),
        .last_o     (ctr_last),
        .last_nxt_o (ctr_last_nxt)
    );

    assign col_o    = ctr_col;
    assign row_o    = ctr_row;
    assign sample_o = sample_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                valid_o <= 1'b0;
                last_o  <= 1'b0;
                busy_o  <= 1'b0;
                x_o     <= '0;
                y_o     <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            state_q <= RUN;
                            valid_o <= 1'b1;
                            busy_o  <= 1'b1;
                            last_o  <= start_last;
                            x_o     <= to_fx('0, dx0);
                            y_o     <= to_fx('0, dy0);
                        end else if (start_hit) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (frame_end) begin
                            state_q <= DONE;
                            valid_o <= 1'b0;
                            last_o  <= 1'b0;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            x_o     <= '0;
                            y_o     <= '0;
                        end else if (xfer) begin
                            last_o <= last_nxt;
                            x_o    <= to_fx(nxt_tag.col, dx_nxt);
                            y_o    <= to_fx(nxt_tag.row, dy_nxt);
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
